// File: rtl/slot_reel_bank_if.sv
// Button and reel-display signals shared between the reel bank and its driver.
interface slot_reel_bank_if #(
   parameter int REELS = 3,
   parameter int SW    = 3
);
   logic                  btn;
   logic [REELS*SW-1:0]   slot_pic;
   logic                  busy;
   logic                  done;
   logic                  win;

   modport master (output btn, input slot_pic, busy, done, win);
   modport slave  (input btn, output slot_pic, busy, done, win);
endinterface

// File: rtl/slot_reel_bank.sv
// Slot-machine reel bank: one button starts the reels and staggers their stops, then reports a win.
// Optional SLOT_AUTOSTOP_EN stops the spin by itself after AUTO_SPIN advances.
module slot_reel_bank #(
   parameter int REELS     = 3,
   parameter int SYMBOLS   = 5,
   parameter int SW        = 3,
   parameter int STOP_GAP  = 4,
   parameter int AUTO_SPIN = 32
) (
   input  logic             clk,
   input  logic             clr,
   slot_reel_bank_if.slave  bus
);
   localparam int STOP_LEN = (REELS - 1) * STOP_GAP;
   localparam int CW       = $clog2(STOP_LEN + 1);
   localparam int NW       = $clog2(AUTO_SPIN + 1);

   typedef enum logic [1:0] {IDLE, SPIN, STOP, RESULT} state_t;
   typedef logic [SW:0] ext_t;

   state_t          state_q, state_d;
   logic            btn_q;
   logic [SW-1:0]   reel_q [REELS];
   logic [SW-1:0]   reel_d [REELS];
   logic [CW-1:0]   stop_cnt_q, stop_cnt_d;
   logic [NW-1:0]   spin_cnt_q, spin_cnt_d;
   logic            win_q, win_d;
   logic            press;
   logic            stop_evt;
   logic [REELS*SW-1:0] pic;

   // Steps never reach SYMBOLS, so a single conditional subtraction wraps correctly.
   function automatic logic [SW-1:0] step(input logic [SW-1:0] v, input int k);
      ext_t s;
      s = ext_t'(v) + ext_t'(k + 1);
      if (s >= ext_t'(SYMBOLS)) s = s - ext_t'(SYMBOLS);
      return s[SW-1:0];
   endfunction

   assign press = btn_q & ~bus.btn;

`ifdef SLOT_AUTOSTOP_EN
   assign stop_evt = press | (spin_cnt_q == NW'(AUTO_SPIN));
`else
   assign stop_evt = press;
`endif

   always_comb begin
      state_d    = state_q;
      stop_cnt_d = stop_cnt_q;
      spin_cnt_d = spin_cnt_q;
      win_d      = win_q;
      for (int k = 0; k < REELS; k++) reel_d[k] = reel_q[k];

      case (state_q)
         IDLE: begin
            if (press) begin
               state_d    = SPIN;
               win_d      = 1'b0;
               spin_cnt_d = '0;
            end
         end
         SPIN: begin
            if (stop_evt) begin
               state_d    = STOP;
               stop_cnt_d = '0;
            end else begin
               for (int k = 0; k < REELS; k++) reel_d[k] = step(reel_q[k], k);
               if (spin_cnt_q != {NW{1'b1}}) spin_cnt_d = spin_cnt_q + 1'b1;
            end
         end
         STOP: begin
            // Reel 0 stays frozen; reel k keeps turning for k*STOP_GAP edges.
            for (int k = 1; k < REELS; k++) begin
               if (stop_cnt_q < CW'(k * STOP_GAP)) reel_d[k] = step(reel_q[k], k);
            end
            stop_cnt_d = stop_cnt_q + 1'b1;
            if (stop_cnt_q == CW'(STOP_LEN - 1)) begin
               state_d = RESULT;
               win_d   = 1'b1;
               for (int k = 1; k < REELS; k++) begin
                  if (reel_d[k] != reel_d[0]) win_d = 1'b0;
               end
            end
         end
         RESULT: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         state_q    <= IDLE;
         btn_q      <= 1'b1;
         stop_cnt_q <= '0;
         spin_cnt_q <= '0;
         win_q      <= 1'b0;
         for (int k = 0; k < REELS; k++) reel_q[k] <= '0;
      end else begin
         state_q    <= state_d;
         btn_q      <= bus.btn;
         stop_cnt_q <= stop_cnt_d;
         spin_cnt_q <= spin_cnt_d;
         win_q      <= win_d;
         for (int k = 0; k < REELS; k++) reel_q[k] <= reel_d[k];
      end
   end

   always_comb begin
      pic = '0;
      for (int k = 0; k < REELS; k++) pic[k*SW +: SW] = reel_q[k];
   end

   assign bus.slot_pic = pic;
   assign bus.busy     = (state_q == SPIN) || (state_q == STOP);
   assign bus.done     = (state_q == RESULT);
   assign bus.win      = win_q;
endmodule

// File: tb/tb_slot_reel_bank.sv
// Randomised scoreboard bench: two reel banks (STOP_GAP 4 and 5) share one button.
module tb_slot_reel_bank;
   localparam int R = 3;
   localparam int S = 5;

   typedef struct {
      logic [8:0] pic;
      logic       win;
      int         cyc;
   } exp_t;

   logic clk;
   logic clr;
   logic btn;
   int   cyc;
   int   tests;
   int   fails;
   int   m4 [R];
   int   m5 [R];
   exp_t q4 [$];
   exp_t q5 [$];
   exp_t e4;
   exp_t e5;

   slot_reel_bank_if #(.REELS(3), .SW(3)) bus ();
   slot_reel_bank_if #(.REELS(3), .SW(3)) bus5 ();

   assign bus.btn  = btn;
   assign bus5.btn = btn;

   slot_reel_bank #(.REELS(3), .SYMBOLS(5), .SW(3), .STOP_GAP(4), .AUTO_SPIN(32)) u_dut (
      .clk (clk),
      .clr (clr),
      .bus (bus.slave)
   );

   slot_reel_bank #(.REELS(3), .SYMBOLS(5), .SW(3), .STOP_GAP(5), .AUTO_SPIN(32)) u_dut5 (
      .clk (clk),
      .clr (clr),
      .bus (bus5.slave)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, required %0h", name, act, exp);
      end
   endtask

   // Reference: reel k moves (k+1) per spin edge and (k+1) per each of its k*gap stop edges.
   task automatic model_spin(input int n, output logic [8:0] p4, output logic [8:0] p5,
                             output logic w4, output logic w5);
      for (int k = 0; k < R; k++) begin
         m4[k] = (m4[k] + (k + 1) * (n + k * 4)) % S;
         m5[k] = (m5[k] + (k + 1) * (n + k * 5)) % S;
      end
      p4 = '0;
      p5 = '0;
      for (int k = 0; k < R; k++) begin
         p4[k*3 +: 3] = m4[k][2:0];
         p5[k*3 +: 3] = m5[k][2:0];
      end
      w4 = (m4[0] == m4[1]) && (m4[1] == m4[2]);
      w5 = (m5[0] == m5[1]) && (m5[1] == m5[2]);
   endtask

   always @(negedge clk) begin
      if (bus.done === 1'b1) begin
         if (q4.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL done4_unexpected: got done=1, required no pulse");
         end else begin
            e4 = q4.pop_front();
            check("pic4", 32'(bus.slot_pic), 32'(e4.pic));
            check("win4", 32'(bus.win), 32'(e4.win));
            check("done4_cycle", cyc, e4.cyc);
            check("busy4_at_done", 32'(bus.busy), 0);
         end
      end
   end

   always @(negedge clk) begin
      if (bus5.done === 1'b1) begin
         if (q5.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL done5_unexpected: got done=1, required no pulse");
         end else begin
            e5 = q5.pop_front();
            check("pic5", 32'(bus5.slot_pic), 32'(e5.pic));
            check("win5", 32'(bus5.win), 32'(e5.win));
            check("done5_cycle", cyc, e5.cyc);
         end
      end
   end

   task automatic wait_idle(input int budget);
      int t = 0;
      while (((bus.busy | bus.done | bus5.busy | bus5.done) !== 1'b0) && (t < budget)) begin
         @(negedge clk);
         t++;
      end
      if (t >= budget) begin
         tests++;
         fails++;
         $display("FAIL idle_timeout: got still busy after %0d cycles, required idle", t);
      end
   endtask

   task automatic do_reset();
      clr = 1'b1;
      #1;
      @(negedge clk);
      clr = 1'b0;
      for (int k = 0; k < R; k++) begin
         m4[k] = 0;
         m5[k] = 0;
      end
   endtask

   // Called at a negedge with n spin advances already elapsed.
   task automatic stop_and_check(input int n, input bit poke);
      logic [8:0] p4, p5;
      logic       w4, w5;
      model_spin(n, p4, p5, w4, w5);
      q4.push_back('{pic: p4, win: w4, cyc: cyc + 1 + 2 * 4});
      q5.push_back('{pic: p5, win: w5, cyc: cyc + 1 + 2 * 5});
      btn = 1'b0;
      @(negedge clk);
      btn = 1'b1;
      if (poke) begin
         @(negedge clk);
         btn = 1'b0;
         @(negedge clk);
         btn = 1'b1;
         check("busy_after_stop_poke", 32'(bus.busy), 1);
      end
      wait_idle(100);
      repeat (3) @(negedge clk);
      check("win4_hold", 32'(bus.win), 32'(w4));
      check("win5_hold", 32'(bus5.win), 32'(w5));
      check("pic4_hold", 32'(bus.slot_pic), 32'(p4));
   endtask

   task automatic do_spin(input int n, input bit poke);
      btn = 1'b0;
      @(negedge clk);
      btn = 1'b1;
      repeat (n) @(negedge clk);
      stop_and_check(n, poke);
   endtask

   initial begin
      int   start0;
      bit   all_busy;
      logic [8:0] p4, p5;
      logic       w4, w5;
      cyc   = 0;
      tests = 0;
      fails = 0;
      btn   = 1'b1;
      clr   = 1'b0;
      #2 clr = 1'b1;
      #1;
      check("rst_pic", 32'(bus.slot_pic), 0);
      check("rst_busy", 32'(bus.busy), 0);
      check("rst_done", 32'(bus.done), 0);
      check("rst_win", 32'(bus.win), 0);
      @(negedge clk);
      do_reset();

      do_spin(5, 1'b0);
      check("n5_gap4_pic", 32'(bus.slot_pic), 32'h118);
      check("n5_gap4_win", 32'(bus.win), 0);

      do_reset();
      do_spin(10, 1'b0);
      check("n10_gap5_pic", 32'(bus5.slot_pic), 32'h000);
      check("n10_gap5_win", 32'(bus5.win), 1);

      do_reset();
      do_spin(7, 1'b0);
      check("n7_gap5_pic", 32'(bus5.slot_pic), 32'h062);
      check("n7_gap5_win", 32'(bus5.win), 0);

      do_reset();
      do_spin(5, 1'b1);
      check("poke_n5_gap4_pic", 32'(bus.slot_pic), 32'h118);

      // Held button: one start only, reel 0 advances every edge.
      start0 = m4[0];
      btn = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         check("held_busy", 32'(bus.busy), 1);
         check("held_reel0", 32'(bus.slot_pic[2:0]), (start0 + i) % S);
      end
      btn = 1'b1;
      @(negedge clk);
      stop_and_check(20, 1'b0);

      // Reset in the middle of a spin aborts it with no done pulse.
      btn = 1'b0;
      @(negedge clk);
      btn = 1'b1;
      repeat (3) @(negedge clk);
      clr = 1'b1;
      #1;
      check("midspin_pic", 32'(bus.slot_pic), 0);
      check("midspin_busy", 32'(bus.busy), 0);
      check("midspin_done", 32'(bus.done), 0);
      check("midspin_win", 32'(bus.win), 0);
      @(negedge clk);
      clr = 1'b0;
      for (int k = 0; k < R; k++) begin
         m4[k] = 0;
         m5[k] = 0;
      end
      repeat (15) @(negedge clk);

      for (int it = 0; it < 20; it++) begin
         do_spin(int'($urandom_range(1, 25)), bit'($urandom_range(0, 1)));
      end

      do_reset();
`ifdef SLOT_AUTOSTOP_EN
      model_spin(32, p4, p5, w4, w5);
      q4.push_back('{pic: p4, win: w4, cyc: cyc + 34 + 2 * 4});
      q5.push_back('{pic: p5, win: w5, cyc: cyc + 34 + 2 * 5});
      btn = 1'b0;
      @(negedge clk);
      btn = 1'b1;
      wait_idle(200);
      check("auto_pic", 32'(bus.slot_pic), 32'h012);
      check("auto_win", 32'(bus.win), 0);
`else
      p4 = '0;
      p5 = '0;
      w4 = 1'b0;
      w5 = 1'b0;
      all_busy = 1'b1;
      btn = 1'b0;
      @(negedge clk);
      btn = 1'b1;
      for (int i = 0; i < 1000; i++) begin
         @(negedge clk);
         if (bus.busy !== 1'b1) all_busy = 1'b0;
      end
      check("long_spin_busy", 32'(all_busy), 1);
      stop_and_check(1000, 1'b0);
`endif

      repeat (5) @(negedge clk);
      check("q4_drained", q4.size(), 0);
      check("q5_drained", q5.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got no finish, required end of run");
      $fatal(1);
   end
endmodule
